conv_seq_ctrl: RTL
==================

// Module: conv_seq_ctrl
// PURPOSE
//  Sequencer + MAC for 1-D valid convolution y[n] = sum_k x[n+k]*f[k], N_X=8 x N_F=4 -> N_Y=5.
//  Sits inside conv_8_4 between the x/f sample memories (sync read, 1-cycle latency) and the y stream output.
//  Starts when both memories are full, walks read addresses, accumulates, and emits each y over valid/ready.
//  Pulses conv_done so the memory write controllers rewind and re-accept data.
// PARAMETERS
//  N_X    8   samples in x memory
//  N_F    4   taps in f memory
//  LOG_X  3   x address width (>= clog2(N_X))
//  LOG_F  2   f address width (>= clog2(N_F))
//  D_W    8   signed sample/tap width
//  ACC_W  18  signed accumulator/output width (>= 2*D_W + clog2(N_F))
// PORTS
//  clk           in   1      clock
//  reset         in   1      synchronous, active-high reset
//  x_full        in   1      x memory holds N_X valid samples
//  f_full        in   1      f memory holds N_F valid taps
//  addr_x        out  LOG_X  x memory read address
//  addr_f        out  LOG_F  f memory read address
//  x_rd_data     in   D_W    signed x read data, valid 1 cycle after addr_x
//  f_rd_data     in   D_W    signed f read data, valid 1 cycle after addr_f
//  m_data_out_y  out  ACC_W  signed result y[n]
//  m_valid_y     out  1      m_data_out_y valid
//  m_ready_y     in   1      downstream accepts y
//  conv_done     out  1      1-cycle pulse after y[N_Y-1] accepted
//  busy          out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, n=0, k=0, acc=0; addr_x=0, addr_f=0, m_data_out_y=0, m_valid_y=0, conv_done=0, busy=0.
//  Reset mid-operation aborts immediately; partial y discarded, no conv_done.
//  States (all outputs registered):
//   IDLE : x_full&&f_full -> RUN with n=0,k=0. x_full/f_full sampled only here.
//   RUN  : addr_x=n+k, addr_f=k each cycle, k=0..N_F-1 (N_F cycles); after k=N_F-1 -> DRAIN.
//          Read data of tap k arrives the following cycle: k=0 data loads acc<=x*f; k>0 adds acc<=acc+x*f.
//   DRAIN: 1 cycle, accumulates last tap; -> OUT with m_data_out_y<=final acc, m_valid_y<=1.
//   OUT  : hold m_data_out_y/m_valid_y stable while !m_ready_y. On m_valid_y&&m_ready_y:
//          m_valid_y<=0; if n==N_Y-1 -> DONE, else n<=n+1, k<=0 -> RUN.
//   DONE : conv_done=1 for exactly 1 cycle -> IDLE; n, k, addresses return to 0.
//  Timing per y (N_F=4): 4 RUN + 1 DRAIN + >=1 OUT = 6 cycles minimum; full frame min 30 cycles + DONE.
//  Arithmetic: D_W x D_W signed product (2*D_W bits), sign-extended to ACC_W; no overflow possible at defaults.
//  Addresses never exceed N_X-1 / N_F-1; no wrap.
//  Upstream deasserts x_full/f_full on the edge ending DONE; a full seen in IDLE starts a new frame with no extra gap.
//  m_ready_y high while m_valid_y low is ignored.
// CONFIGURATION
//  CONV_RELU_EN defined: value loaded into m_data_out_y at DRAIN->OUT is max(acc,0); acc itself unchanged.
//  CONV_RELU_EN undefined: m_data_out_y = acc, signed, negative values passed through.
// TESTING
//  x=1..8, f=1,1,1,1, m_ready_y=1 -> y=10,14,18,22,26, each 6 cycles apart, conv_done 1 cycle after last.
//  x=1..8, f=1,2,3,4 -> y=30,40,50,60,70; addr_x seq for y[2] = 2,3,4,5, addr_f = 0,1,2,3.
//  Same as first, m_ready_y low 3 cycles at each y -> data/valid held stable, values unchanged, 5 transfers.
//  x=-128 all, f=-128 all -> every y=65536; x=-128 all, f=127 all -> y=-65024 (0 with CONV_RELU_EN).
//  reset asserted during RUN of y[2] -> next cycle IDLE, all outputs 0; re-run with full -> y=10..26 again.
//  x_full=1, f_full=0 for 20 cycles -> stays IDLE, busy=0, addr 0; assert f_full -> RUN next cycle.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Sequencer + MAC for 1-D valid convolution (N_X samples x N_F taps), streaming y over valid/ready.
// Optional CONV_RELU_EN clamps emitted y to max(acc,0); default build passes signed results through.
module conv_seq_ctrl #(
    parameter int N_X   = 8,
    parameter int N_F   = 4,
    parameter int LOG_X = 3,
    parameter int LOG_F = 2,
    parameter int D_W   = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    x_full,
    input  logic                    f_full,
    output logic [LOG_X-1:0]        addr_x,
    output logic [LOG_F-1:0]        addr_f,
    input  logic signed [D_W-1:0]   x_rd_data,
    input  logic signed [D_W-1:0]   f_rd_data,
    output logic signed [ACC_W-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y,
    output logic                    conv_done,
    output logic                    busy
);

    // state | meaning
    // IDLE  | waiting for both sample memories to be full
    // RUN   | issuing tap reads k=0..N_F-1, accumulating the previous tap's data
    // DRAIN | accumulating the last tap, loading the output register
    // OUT   | presenting y[n] until accepted
    // DONE  | one-cycle conv_done pulse, then back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;

    localparam int N_Y = N_X - N_F + 1;
    localparam logic [LOG_F-1:0] K_LAST = LOG_F'(N_F - 1);
    localparam logic [LOG_X-1:0] N_LAST = LOG_X'(N_Y - 1);

    state_t                  state, state_nx;
    logic [LOG_X-1:0]        n, n_nx, addr_x_nx;
    logic [LOG_F-1:0]        k, k_nx, addr_f_nx;
    logic signed [ACC_W-1:0] acc, acc_nx, y_nx, acc_sum, prod_ext;
    logic signed [2*D_W-1:0] x_ext, f_ext, prod;
    logic                    valid_nx, done_nx;

    assign x_ext    = {{D_W{x_rd_data[D_W-1]}}, x_rd_data};
    assign f_ext    = {{D_W{f_rd_data[D_W-1]}}, f_rd_data};
    assign prod     = x_ext * f_ext;
    assign prod_ext = {{(ACC_W-2*D_W){prod[2*D_W-1]}}, prod};
    assign acc_sum  = acc + prod_ext;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            n            <= '0;
            k            <= '0;
            acc          <= '0;
            addr_x       <= '0;
            addr_f       <= '0;
            m_data_out_y <= '0;
            m_valid_y    <= 1'b0;
            conv_done    <= 1'b0;
        end else begin
            state        <= state_nx;
            n            <= n_nx;
            k            <= k_nx;
            acc          <= acc_nx;
            addr_x       <= addr_x_nx;
            addr_f       <= addr_f_nx;
            m_data_out_y <= y_nx;
            m_valid_y    <= valid_nx;
            conv_done    <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n_nx      = n;
        k_nx      = k;
        acc_nx    = acc;
        addr_x_nx = addr_x;
        addr_f_nx = addr_f;
        y_nx      = m_data_out_y;
        valid_nx  = m_valid_y;
        done_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (x_full && f_full) begin
                    state_nx  = S_RUN;
                    n_nx      = '0;
                    k_nx      = '0;
                    addr_x_nx = '0;
                    addr_f_nx = '0;
                end
            end
            S_RUN: begin
                // Read data lags the address by one cycle: data of tap k-1 is present now.
                if (k == LOG_F'(1))
                    acc_nx = prod_ext;
                else if (k != '0)
                    acc_nx = acc_sum;
                if (k == K_LAST) begin
                    state_nx = S_DRAIN;
                end else begin
                    k_nx      = k + LOG_F'(1);
                    addr_x_nx = n + LOG_X'(k) + LOG_X'(1);
                    addr_f_nx = k + LOG_F'(1);
                end
            end
            S_DRAIN: begin
                acc_nx = acc_sum;
`ifdef CONV_RELU_EN
                y_nx = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
                y_nx = acc_sum;
`endif
                valid_nx = 1'b1;
                state_nx = S_OUT;
            end
            S_OUT: begin
                if (m_ready_y) begin
                    valid_nx = 1'b0;
                    k_nx     = '0;
                    if (n == N_LAST) begin
                        state_nx  = S_DONE;
                        done_nx   = 1'b1;
                        n_nx      = '0;
                        addr_x_nx = '0;
                        addr_f_nx = '0;
                    end else begin
                        state_nx  = S_RUN;
                        n_nx      = n + LOG_X'(1);
                        addr_x_nx = n + LOG_X'(1);
                        addr_f_nx = '0;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
